// File: rtl/mod_inverse.sv
// Sequential modular inverse: a^-1 mod Q computed as a^(Q-2) mod Q by
// left-to-right square-and-multiply over one pipelined Barrett multiplier.

module mod_mult #(
    parameter int          WIDTH     = 32,
    parameter int unsigned Q         = 8380417,
    parameter int          K_BARRETT = 23,
    parameter int unsigned MU        = 8396807
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);
    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] Q_P  = PW'(Q);
    localparam logic [PW-1:0] Q2_P = Q_P << 1;

    logic [WIDTH-1:0] x_s0, y_s0;
    logic [PW-1:0]    p_s1, p_s2, q_s2;
    logic [PW-1:0]    t;
    logic [WIDTH-1:0] red;
    logic [WIDTH-1:0] z_s3;

    // Barrett estimate undershoots by at most 2Q, so two conditional subtractions finish it
    always_comb begin
        t   = p_s2 - q_s2 * Q_P;
        red = WIDTH'(t);
        if (t >= Q2_P) begin
            red = WIDTH'(t - Q2_P);
        end else if (t >= Q_P) begin
            red = WIDTH'(t - Q_P);
        end
    end

    // Datapath registers carry no reset; the controller ignores stale contents
    always_ff @(posedge clk) begin
        x_s0 <= x;
        y_s0 <= y;
        p_s1 <= PW'(x_s0) * PW'(y_s0);
        p_s2 <= p_s1;
        q_s2 <= PW'(({{PW{1'b0}}, p_s1 >> (K_BARRETT - 1)} * (2 * PW)'(MU)) >> (K_BARRETT + 1));
        z_s3 <= red;
    end

    assign z = z_s3;
endmodule

module mod_inverse #(
    parameter int          WIDTH        = 32,
    parameter int unsigned Q            = 8380417,
    parameter int          K_BARRETT    = 23,
    parameter int unsigned MU           = 8396807,
    parameter int          MULT_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    localparam int unsigned      EXP_I    = Q - 2;
    localparam int               EXP_BITS = $clog2(EXP_I + 1);
    localparam logic [WIDTH-1:0] EXP      = WIDTH'(EXP_I);
    localparam logic [WIDTH-1:0] Q_W      = WIDTH'(Q);
    localparam int               IDX_W    = $clog2(EXP_BITS);
    localparam int               CNT_W    = $clog2(MULT_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {SQR, MUL} phase_t;

    state_t           state, state_next;
    phase_t           phase, phase_next;
    logic [WIDTH-1:0] r, r_next, base, base_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] result_q, result_next;
    logic             err_q, err_next;
    logic [WIDTH-1:0] op_y, prod;

    // Operands derive from r and phase only, so they hold steady through WAIT
    assign op_y = (phase == SQR) ? r : base;

    mod_mult #(
        .WIDTH(WIDTH), .Q(Q), .K_BARRETT(K_BARRETT), .MU(MU)
    ) u_mult (
        .clk(clk),
        .x  (r),
        .y  (op_y),
        .z  (prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= SQR;
            r        <= '0;
            base     <= '0;
            idx      <= '0;
            cnt      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            r        <= r_next;
            base     <= base_next;
            idx      <= idx_next;
            cnt      <= cnt_next;
            result_q <= result_next;
            err_q    <= err_next;
        end
    end

    // The exponent's top bit seeds r with a; each lower bit costs a square plus an optional multiply
    always_comb begin
        state_next  = state;
        phase_next  = phase;
        r_next      = r;
        base_next   = base;
        idx_next    = idx;
        cnt_next    = cnt;
        result_next = result_q;
        err_next    = err_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (a != '0 && a < Q_W) begin
                        base_next   = a;
                        r_next      = a;
                        idx_next    = IDX_W'(EXP_BITS - 2);
                        phase_next  = SQR;
                        err_next    = 1'b0;
                        result_next = '0;
                        state_next  = ISSUE;
                    end else begin
                        result_next = '0;
                        err_next    = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = CNT_W'(MULT_LATENCY - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    r_next = prod;
                    if (phase == SQR && EXP[idx]) begin
                        phase_next = MUL;
                        state_next = ISSUE;
                    end else if (idx == '0) begin
                        result_next = prod;
                        state_next  = DONE;
                    end else begin
                        idx_next   = idx - 1'b1;
                        phase_next = SQR;
                        state_next = ISSUE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign err       = err_q;
endmodule
